// File: rtl/ram_port_initiator_pkg.sv
// Shared constants and helpers for the RAM port initiator and its response FIFO.
package ram_port_initiator_pkg;

  localparam int unsigned RESP_FIFO_DEPTH = 4;
  localparam int unsigned RESP_FIFO_PTR_W = 2;
  localparam int unsigned RESP_FIFO_CNT_W = RESP_FIFO_PTR_W + 1;

  typedef logic [RESP_FIFO_PTR_W-1:0] fifo_ptr_t;
  typedef logic [RESP_FIFO_CNT_W-1:0] fifo_cnt_t;

  // Only the non-registered (1) and registered (2) RAM output variants exist.
  function automatic bit latency_ok(int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/ram_port_initiator_if.sv
// Request/response stream bundle between a client and the RAM port initiator.
interface ram_port_initiator_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/ram_resp_fifo.sv
// Four-entry synchronous FIFO with a registered head, holding read responses.
module ram_resp_fifo
  import ram_port_initiator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output fifo_cnt_t             count
);

  logic [DATA_WIDTH-1:0] mem_q [RESP_FIFO_DEPTH];
  fifo_ptr_t             wr_ptr_q, wr_ptr_d;
  fifo_ptr_t             rd_ptr_q, rd_ptr_d;
  fifo_cnt_t             count_q, count_d;
  logic                  do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == fifo_cnt_t'(RESP_FIFO_DEPTH));
  assign count    = count_q;
  assign data_out = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + fifo_cnt_t'(push) - fifo_cnt_t'(do_pop);
  end

  // Storage is cleared too so the head reads as zero out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= data_in;
      end
    end
  end

  push_when_full_a: assert property (@(posedge clock) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/ram_port_initiator.sv
// Drives one block-RAM port from a request stream and returns read data as a
// backpressured response stream, hiding the RAM read latency behind credits.
module ram_port_initiator
  import ram_port_initiator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  ram_port_initiator_if.slave   bus,
  output logic                  ram_enable,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_idata,
  input  logic [DATA_WIDTH-1:0] ram_odata,
  output logic                  busy
);

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("ram_port_initiator: LATENCY must be 1 or 2");
  end

  logic               ready_q;
  logic [LATENCY-1:0] tag_q, tag_d;
  logic [1:0]         inflight_q, inflight_d;
  fifo_cnt_t          fifo_count;
  fifo_cnt_t          credit_used;
  logic               fifo_empty;
  logic               fifo_full;
  logic               req_ready;
  logic               accept;
  logic               rd_accept;
  logic               push;
  logic               pop;

  // Credits are taken from registered state only, so ready never sees valid.
  assign credit_used = fifo_cnt_t'(inflight_q) + fifo_count;
  assign req_ready   = ready_q && (credit_used < fifo_cnt_t'(RESP_FIFO_DEPTH));
  assign accept      = bus.req_valid && req_ready;
  assign rd_accept   = accept && !bus.req_write;
  assign push        = tag_q[LATENCY-1];
  assign pop         = bus.resp_valid && bus.resp_ready;

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = !fifo_empty;

  assign ram_enable = accept;
  assign ram_write  = bus.req_write && accept;
  assign ram_addr   = bus.req_addr;
  assign ram_idata  = bus.req_data;

  assign busy = (inflight_q != '0) || !fifo_empty;

  always_comb begin
    tag_d    = '0;
    tag_d[0] = rd_accept;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    inflight_d = inflight_q + 2'(rd_accept) - 2'(push);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q    <= 1'b0;
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      ready_q    <= 1'b1;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  ram_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .data_in  (ram_odata),
    .pop      (pop),
    .data_out (bus.resp_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  // fifo_full only feeds the overflow assertion inside the FIFO.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ram_port_initiator.sv
// Scoreboard bench: lane 0 runs a LATENCY=1 initiator, lane 1 a LATENCY=2 one.
module tb_ram_port_initiator;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic [1:0]    req_valid, req_write, resp_ready;
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_data [2];
  wire  [1:0]    req_ready, resp_valid, ram_enable, ram_write, busy;
  wire  [DW-1:0] resp_data [2];
  wire  [DW-1:0] ram_idata [2];
  wire  [DW-1:0] ram_odata [2];
  wire  [AW-1:0] ram_addr [2];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    ram_port_initiator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    assign bus.req_valid  = req_valid[g];
    assign bus.req_write  = req_write[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_data   = req_data[g];
    assign bus.resp_ready = resp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign resp_valid[g]  = bus.resp_valid;
    assign resp_data[g]   = bus.resp_data;

    ram_port_initiator #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .LATENCY    (g + 1)
    ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .bus        (bus),
      .ram_enable (ram_enable[g]),
      .ram_write  (ram_write[g]),
      .ram_addr   (ram_addr[g]),
      .ram_idata  (ram_idata[g]),
      .ram_odata  (ram_odata[g]),
      .busy       (busy[g])
    );

    // RAM port model: rd_q is the non-registered output, out_q the registered one.
    logic [DW-1:0] ram_mem [1024];
    logic [DW-1:0] rd_q, out_q;
    initial begin
      for (int i = 0; i < 1024; i++) ram_mem[i] = DW'(i);
      rd_q  = '0;
      out_q = '0;
    end
    always @(posedge clock) begin
      if (ram_enable[g]) begin
        if (ram_write[g]) ram_mem[ram_addr[g]] <= ram_idata[g];
        else              rd_q <= ram_mem[ram_addr[g]];
      end
      out_q <= rd_q;
    end
    if (g == 0) begin : g_l1
      assign ram_odata[g] = rd_q;
    end else begin : g_l2
      assign ram_odata[g] = out_q;
    end
  end

  int            n_checks = 0;
  int            n_fail = 0;
  int            n_resp = 0;
  int            cur = 0;
  bit            rnd_bp = 1'b0;
  logic [DW-1:0] ref_mem [2][1024];
  logic [DW-1:0] sb [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (lane %0d, t=%0t)", tag, obs, exp, cur, $time);
    end
  endtask

  // Monitor: requests update the model at acceptance, responses pop the scoreboard.
  initial begin : monitor
    logic [DW-1:0] exp;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (req_valid[cur] && req_ready[cur]) begin
          if (req_write[cur]) ref_mem[cur][req_addr[cur]] = req_data[cur];
          else                sb.push_back(ref_mem[cur][req_addr[cur]]);
        end
        if (resp_valid[cur] && resp_ready[cur]) begin
          n_resp++;
          if (sb.size() == 0) begin
            check_eq("spurious_resp", 32'(resp_valid[cur]), 32'd0);
          end else begin
            exp = sb.pop_front();
            check_eq("resp_data", 32'(resp_data[cur]), 32'(exp));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int stalls);
    int n;
    req_write[cur] = w;
    req_addr[cur]  = a;
    req_data[cur]  = d;
    req_valid[cur] = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (req_ready[cur]) break;
      n++;
      if (n > 200) begin
        check_eq("req_accept_timeout", 32'(req_ready[cur]), 32'd1);
        break;
      end
      @(posedge clock); #1;
      if (rnd_bp) resp_ready[cur] = 1'($urandom_range(0, 1));
    end
    @(posedge clock); #1;
    if (rnd_bp) resp_ready[cur] = 1'($urandom_range(0, 1));
    stalls = n;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    req_valid[cur]  = 1'b0;
    resp_ready[cur] = 1'b1;
    while ((busy[cur] || sb.size() != 0) && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check_eq("drain_busy", 32'(busy[cur]), 32'd0);
    check_eq("drain_scoreboard", 32'(sb.size()), 32'd0);
  endtask

  task automatic test_write_read();
    int lat, st;
    resp_ready[cur] = 1'b0;
    @(posedge clock); #1;
    req_write[cur] = 1'b1; req_addr[cur] = 10'h005; req_data[cur] = 8'hA5; req_valid[cur] = 1'b1;
    @(negedge clock);
    check_eq("ram_write_pulse", 32'(ram_write[cur]), 32'd1);
    @(posedge clock); #1;
    req_valid[cur] = 1'b0;
    @(negedge clock);
    check_eq("ram_write_low", 32'(ram_write[cur]), 32'd0);
    @(posedge clock); #1;
    issue(1'b0, 10'h005, 8'h00, st);
    req_valid[cur] = 1'b0;
    lat = 0;
    while (!resp_valid[cur] && lat < 6) begin
      @(posedge clock); #1;
      lat++;
    end
    check_eq("read_latency", 32'(lat), 32'(cur + 1));
    check_eq("head_data", 32'(resp_data[cur]), 32'hA5);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int st, tot, r0;
    tot = 0;
    r0 = n_resp;
    resp_ready[cur] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, AW'(i), 8'h00, st);
      tot += st;
    end
    req_valid[cur] = 1'b0;
    repeat (cur + 2) @(posedge clock);
    #1;
    check_eq("b2b_stalls", 32'(tot), 32'd0);
    check_eq("b2b_resp_count", 32'(n_resp - r0), 32'd16);
    check_eq("b2b_idle", 32'(busy[cur]), 32'd0);
  endtask

  task automatic test_backpressure();
    int acc, r0;
    acc = 0;
    resp_ready[cur] = 1'b0;
    req_write[cur]  = 1'b0;
    req_addr[cur]   = 10'h020;
    req_valid[cur]  = 1'b1;
    repeat (8) begin
      @(negedge clock);
      if (req_ready[cur]) acc++;
      @(posedge clock); #1;
      req_addr[cur] = AW'(32'h20 + acc);
    end
    check_eq("bp_accepted", 32'(acc), 32'd4);
    r0 = n_resp;
    resp_ready[cur] = 1'b1;
    @(negedge clock);
    check_eq("bp_ready_in_pop_cycle", 32'(req_ready[cur]), 32'd0);
    @(posedge clock); #1;
    resp_ready[cur] = 1'b0;
    @(negedge clock);
    check_eq("bp_ready_after_pop", 32'(req_ready[cur]), 32'd1);
    @(posedge clock); #1;
    req_valid[cur] = 1'b0;
    check_eq("bp_one_pop", 32'(n_resp - r0), 32'd1);
    wait_idle();
  endtask

  task automatic test_interleave();
    int st, r0;
    r0 = n_resp;
    resp_ready[cur] = 1'b1;
    issue(1'b0, 10'h010, 8'h00, st);
    issue(1'b1, 10'h011, 8'h3C, st);
    issue(1'b0, 10'h011, 8'h00, st);
    wait_idle();
    check_eq("interleave_resp_count", 32'(n_resp - r0), 32'd2);
  endtask

  task automatic test_reset_mid_op();
    int st, r0;
    resp_ready[cur] = 1'b0;
    issue(1'b0, 10'h030, 8'h00, st);
    issue(1'b0, 10'h031, 8'h00, st);
    issue(1'b0, 10'h032, 8'h00, st);
    req_valid[cur] = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("reset_resp_valid", 32'(resp_valid[cur]), 32'd0);
    check_eq("reset_busy", 32'(busy[cur]), 32'd0);
    sb.delete();
    @(negedge clock); #2;
    reset_n = 1'b1;
    resp_ready[cur] = 1'b1;
    r0 = n_resp;
    repeat (4) begin
      @(negedge clock);
      check_eq("post_reset_no_resp", 32'(resp_valid[cur]), 32'd0);
    end
    @(posedge clock); #1;
    issue(1'b0, 10'h005, 8'h00, st);
    wait_idle();
    check_eq("post_reset_resp_count", 32'(n_resp - r0), 32'd1);
  endtask

  task automatic test_random(input int n_ops);
    int st, n_rd, r0;
    logic w;
    n_rd = 0;
    r0 = n_resp;
    rnd_bp = 1'b1;
    for (int i = 0; i < n_ops; i++) begin
      w = ($urandom_range(0, 9) < 3);
      if (!w) n_rd++;
      issue(w, AW'($urandom_range(0, 63)), DW'($urandom), st);
      if ($urandom_range(0, 3) == 0) begin
        req_valid[cur] = 1'b0;
        @(posedge clock); #1;
        resp_ready[cur] = 1'($urandom_range(0, 1));
      end
    end
    rnd_bp = 1'b0;
    wait_idle();
    check_eq("random_resp_count", 32'(n_resp - r0), 32'(n_rd));
  endtask

  initial begin : main
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 1024; i++) ref_mem[l][i] = DW'(i);
      req_addr[l] = '0;
      req_data[l] = '0;
    end
    req_valid  = 2'b11;
    req_write  = 2'b11;
    resp_ready = 2'b11;
    reset_n    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int g = 0; g < 2; g++) begin
      cur = g;
      check_eq("rst_req_ready", 32'(req_ready[g]), 32'd0);
      check_eq("rst_resp_valid", 32'(resp_valid[g]), 32'd0);
      check_eq("rst_resp_data", 32'(resp_data[g]), 32'd0);
      check_eq("rst_ram_enable", 32'(ram_enable[g]), 32'd0);
      check_eq("rst_ram_write", 32'(ram_write[g]), 32'd0);
      check_eq("rst_busy", 32'(busy[g]), 32'd0);
    end
    req_valid  = 2'b00;
    req_write  = 2'b00;
    resp_ready = 2'b00;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_eq("ready_gated_l0", 32'(req_ready[0]), 32'd0);
    check_eq("ready_gated_l1", 32'(req_ready[1]), 32'd0);
    @(posedge clock); #1;
    check_eq("ready_set_l0", 32'(req_ready[0]), 32'd1);
    check_eq("ready_set_l1", 32'(req_ready[1]), 32'd1);

    for (int l = 0; l < 2; l++) begin
      cur = l;
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_interleave();
      test_reset_mid_op();
    end

    cur = 1;
    test_random(1000);
    cur = 0;
    test_random(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_initiator.md
Name: ram_port_initiator

Overview:
- Drives one port of the team's fixed-latency dual-port block RAM from a valid/ready request stream, and returns read data as a valid/ready response stream with full backpressure.
- Hides the RAM's 1- or 2-cycle read latency (non-registered or registered output) behind a credit-limited response FIFO.
- Sits between a client such as a DMA or command parser and one RAM port. Two instances can share a dual-port RAM.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 10, RAM address width.
- LATENCY, 1, RAM read latency in clocks: 1 for the non-registered output variant, 2 for the registered output variant. Other values are illegal; an elaboration-time check must fail on them.

Ports:
- clock  in  1  Single clock. Shared with the RAM port it drives.
- reset_n  in  1  Asynchronous, active-low reset.
- req_valid  in  1  Request present.
- req_ready  out  1  Request accepted on a clock edge where req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  Word address.
- req_data  in  DATA_WIDTH  Write data; ignored for reads.
- resp_valid  out  1  Read data available.
- resp_ready  in  1  Consumer takes resp_data on a clock edge where resp_valid && resp_ready.
- resp_data  out  DATA_WIDTH  Read data, in request order.
- ram_enable  out  1  To the RAM port's enable input.
- ram_write  out  1  To the RAM port's write input.
- ram_addr  out  ADDR_WIDTH  To the RAM port's address input.
- ram_idata  out  DATA_WIDTH  To the RAM port's write-data input.
- ram_odata  in  DATA_WIDTH  From the RAM port's read-data output.
- busy  out  1  A read is in flight or the response FIFO is not empty.

Behaviour:
- Reset: the pipe, the FIFO and all counters clear. Outputs are 0 during reset: req_ready, resp_valid, resp_data, ram_enable, ram_write, busy.
- Ready gating: a ready flop clears on reset and sets on the first clock edge after reset_n deasserts. req_ready is low until that flop is set.
- RAM drive (combinational):
  - ram_enable = req_valid && req_ready.
  - ram_write = req_write && ram_enable.
  - ram_addr = req_addr; ram_idata = req_data.
- Writes: produce no response and consume no credit.
- Reads and credits: each read consumes one credit of DEPTH = 4.
  - inflight = reads issued to the RAM whose data has not yet been captured.
  - Credit used = inflight + fifo_count, both registered.
  - req_ready = ready flop && (credit used < DEPTH).
  - req_ready must not depend on req_write or req_valid, so there is no combinational valid-to-ready path.
  - A pop in the same cycle frees its credit from the next cycle, not the current one.
- Read tag pipe: a LATENCY-bit shift register. Bit 0 is set on an accepted read. When the last bit is 1, ram_odata is pushed into the FIFO on that clock edge.
- Latency: a read accepted at edge k is written into the FIFO at edge k+LATENCY. resp_valid is high after that edge; this is 1 cycle more than the raw RAM latency.
- FIFO: 4 entries, registered head.
  - resp_valid = !empty; resp_data = head entry.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo 4.
  - The credit rule means the FIFO never overflows. Assert that a push never happens when the FIFO is full.
- Throughput: with resp_ready held at 1, back-to-back reads sustain 1 per clock for LATENCY 1 and 2. This requires DEPTH >= LATENCY+2.
- Backpressure: with resp_ready = 0, the block accepts exactly DEPTH reads, then req_ready stays 0 until a pop.
- Ordering: responses come out in the order the reads were issued. Interleaved writes do not reorder them.
- Read-after-write to the same address on this port: the RAM returns the new data for a later read. The RAM's read-first/write-first behaviour does not matter, because a write produces no response.
- busy = (inflight != 0) || !empty.
- Reset mid-operation: in-flight reads and FIFO contents are discarded. No stale response appears after reset_n deasserts, even if the RAM output is still changing.

Decomposition:
- Shared package:
  - Constant RESP_FIFO_DEPTH = 4 and its pointer width of 2.
  - Function checking that LATENCY is 1 or 2.
- One sub-module: ram_resp_fifo, a 4-entry synchronous FIFO with async active-low reset. Ports: push, data_in, pop, data_out, empty, full, count.
- The credit logic and tag pipe stay in the top-level block.

Test Plan:
- Reset, then write addr 0x005 data 0xA5, then read 0x005 -> ram_write pulses for one cycle. With LATENCY=1, resp_data = 0xA5 and resp_valid rises 1 edge after the read is accepted; with LATENCY=2, 2 edges after.
- Reads of 0x000..0x00F back-to-back with resp_ready = 1 (RAM preloaded with data = addr) -> req_ready stays 1 throughout. Responses are 0x00..0x0F, one per clock, in order.
- resp_ready = 0 with continuous reads -> exactly 4 accepted, then req_ready = 0. Raising resp_ready for 1 cycle -> one response popped and one new read accepted the next cycle.
- Interleave read 0x010, write 0x011 = 0x3C, read 0x011 -> exactly 2 responses: old[0x010], then 0x3C.
- Pulse reset_n low while 3 reads are in flight -> resp_valid = 0 after reset and no responses appear. The next read of 0x005 returns 0xA5.
- Run with LATENCY=2 and random resp_ready at 50% over 1000 random operations -> scoreboard matches. The FIFO-overflow assertion never fires.
